// File: rtl/imem_loader.sv
// imem_loader: receives a framed byte image over the UART byte stream and
// writes it, one 32-bit little-endian word at a time, into instruction RAM.
// The frame is: 0xA5, N_lo, N_hi, 4*N payload bytes, then one XOR checksum byte.
// The CPU stays held in reset until a whole image has loaded and its
// checksum matches.
module imem_loader #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 2048,
  parameter int TIMEOUT = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  logic             clear,
  output logic             mem_wen,
  output logic [WIDTH-1:0] mem_waddr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             cpu_hold,
  output logic             done,
  output logic             error
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN0 = 3'd1,
    ST_LEN1 = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic          accept_s;
  logic          active_s;
  logic          tmo_hit_s;
  logic          word_done_s;
  logic [15:0]   n_s;
  logic [15:0]   n_r;
  logic [7:0]    n_lo_r;
  logic [15:0]   k_r;
  logic [1:0]    b_r;
  logic [7:0]    csum_r;
  logic [23:0]   word_r;
  logic [TW-1:0] tmo_r;

  // Running checksum step: XOR-accumulate one payload byte.
  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

  // Word count must be non-zero and must fit into the memory.
  function automatic logic len_ok(input logic [15:0] n);
    return (n != 16'd0) && ({1'b0, n} <= 17'(DEPTH));
  endfunction

  // Next-state decode, byte acceptance, idle timeout and write strobe.
  always_comb begin
    state_s     = state_r;
    accept_s    = rx_valid && rx_ready;
    n_s         = {rx_data, n_lo_r};
    active_s    = (state_r == ST_LEN0) || (state_r == ST_LEN1) ||
                  (state_r == ST_DATA) || (state_r == ST_CSUM);
    tmo_hit_s   = active_s && !accept_s && (tmo_r == TW'(TIMEOUT - 1));
    word_done_s = accept_s && (state_r == ST_DATA) && (b_r == 2'd3);
    case (state_r)
      ST_IDLE: begin
        if (accept_s && (rx_data == 8'hA5)) begin
          state_s = ST_LEN0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LEN0: begin
        if (accept_s) begin
          state_s = ST_LEN1;
        end else if (tmo_hit_s) begin
          state_s = ST_ERR;
        end else begin
          state_s = ST_LEN0;
        end
      end
      ST_LEN1: begin
        if (accept_s) begin
          if (len_ok(n_s)) begin
            state_s = ST_DATA;
          end else begin
            state_s = ST_ERR;
          end
        end else if (tmo_hit_s) begin
          state_s = ST_ERR;
        end else begin
          state_s = ST_LEN1;
        end
      end
      ST_DATA: begin
        if (word_done_s && (k_r == (n_r - 16'd1))) begin
          state_s = ST_CSUM;
        end else if (tmo_hit_s) begin
          state_s = ST_ERR;
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_CSUM: begin
        if (accept_s) begin
          if (rx_data == csum_r) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_ERR;
          end
        end else if (tmo_hit_s) begin
          state_s = ST_ERR;
        end else begin
          state_s = ST_CSUM;
        end
      end
      ST_DONE: begin
        if (clear) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      ST_ERR: begin
        if (clear) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_ERR;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register and status outputs, registered from the next state so they track it exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      rx_ready <= 1'b1;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      state_r  <= state_s;
      rx_ready <= (state_s != ST_DONE) && (state_s != ST_ERR);
      cpu_hold <= (state_s != ST_DONE);
      done     <= (state_s == ST_DONE);
      error    <= (state_s == ST_ERR);
    end
  end

  // Idle-cycle timer: cleared by any accepted byte, runs only while inside a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_r <= {TW{1'b0}};
    end else if (accept_s || !active_s) begin
      tmo_r <= {TW{1'b0}};
    end else begin
      tmo_r <= tmo_r + TW'(1);
    end
  end

  // Memory write port: one-cycle strobe; address and data hold between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_wen   <= 1'b0;
      mem_waddr <= {WIDTH{1'b0}};
      mem_wdata <= {WIDTH{1'b0}};
    end else if (word_done_s) begin
      mem_wen   <= 1'b1;
      mem_waddr <= WIDTH'({k_r, 2'b00});
      mem_wdata <= WIDTH'({rx_data, word_r});
    end else begin
      mem_wen   <= 1'b0;
    end
  end

  // Frame datapath: length capture, word/byte indices, lane assembly and checksum.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_lo_r <= 8'd0;
      n_r    <= 16'd0;
      k_r    <= 16'd0;
      b_r    <= 2'd0;
      csum_r <= 8'd0;
      word_r <= 24'd0;
    end else if (accept_s) begin
      case (state_r)
        ST_LEN0: begin
          n_lo_r <= rx_data;
        end
        ST_LEN1: begin
          n_r    <= n_s;
          k_r    <= 16'd0;
          b_r    <= 2'd0;
          csum_r <= 8'd0;
        end
        ST_DATA: begin
          csum_r <= csum_step(csum_r, rx_data);
          b_r    <= b_r + 2'd1;
          case (b_r)
            2'd0:    word_r[7:0]   <= rx_data;
            2'd1:    word_r[15:8]  <= rx_data;
            2'd2:    word_r[23:16] <= rx_data;
            default: k_r           <= k_r + 16'd1;
          endcase
        end
        default: begin
          n_lo_r <= n_lo_r;
        end
      endcase
    end else begin
      n_lo_r <= n_lo_r;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus pushes expected writes derived
// from the word list, a negedge monitor pops and compares on every mem_wen.
module tb_imem_loader;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 64;
  localparam int TIMEOUT = 40;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             clear;
  logic             mem_wen;
  logic [WIDTH-1:0] mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic             cpu_hold;
  logic             done;
  logic             error;

  imem_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .clear(clear), .mem_wen(mem_wen),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passed = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [31:0] fw[$];
  logic [31:0] mon_a;
  logic [31:0] mon_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every write must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && mem_wen) begin
      if (exp_addr.size() == 0) begin
        checks++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write", mem_waddr, mem_wdata);
      end else begin
        mon_a = exp_addr.pop_front();
        mon_d = exp_data.pop_front();
        chk("write_addr", mem_waddr, mon_a);
        chk("write_data", mem_wdata, mon_d);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_cycles(input int n);
    rx_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Present one byte at a negedge; it transfers at the next posedge.
  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    while (!rx_ready && w < 50) begin
      rx_valid = 1'b0;
      @(negedge clk);
      w++;
    end
    if (!rx_ready) chk("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    rx_valid = 1'b0;
    clear    = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input logic h, input logic r);
    chk({tag, "_done"},     {31'd0, done},     {31'd0, d});
    chk({tag, "_error"},    {31'd0, error},    {31'd0, e});
    chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, h});
    chk({tag, "_rx_ready"}, {31'd0, rx_ready}, {31'd0, r});
  endtask

  task automatic check_reset_vals(input string tag);
    check_status(tag, 1'b0, 1'b0, 1'b1, 1'b1);
    chk({tag, "_mem_wen"},   {31'd0, mem_wen}, 32'd0);
    chk({tag, "_mem_waddr"}, mem_waddr,        32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata,        32'd0);
  endtask

  task automatic clear_and_check(input string tag);
    pulse_clear();
    check_status({tag, "_clr"}, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  // Send the frame built from fw; model: every word is written at 4*i,
  // outcome is DONE iff the checksum byte equals XOR of all payload bytes.
  task automatic run_frame(input string tag, input bit corrupt, input logic [7:0] bad, input int maxgap);
    logic [15:0] n;
    logic [7:0]  cs;
    logic [7:0]  bt;
    logic [31:0] w;
    n  = 16'(fw.size());
    cs = 8'd0;
    for (int i = 0; i < fw.size(); i++) begin
      exp_addr.push_back(32'(i) * 32'd4);
      exp_data.push_back(fw[i]);
    end
    send_byte(8'hA5);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    for (int i = 0; i < fw.size(); i++) begin
      w = fw[i];
      for (int j = 0; j < 4; j++) begin
        bt = 8'((w >> (8 * j)) & 32'hFF);
        cs = cs ^ bt;
        send_byte(bt);
        if (maxgap > 0) idle_cycles($urandom_range(maxgap, 0));
      end
    end
    if (corrupt) begin
      bt = (bad == cs) ? (bad ^ 8'h01) : bad;
    end else begin
      bt = cs;
    end
    send_byte(bt);
    idle_cycles(2);
    check_status(tag, !corrupt, corrupt, corrupt, 1'b0);
    chk({tag, "_writes_drained"}, 32'(exp_addr.size()), 32'd0);
  endtask

  task automatic bad_len(input string tag, input logic [15:0] n);
    send_byte(8'hA5);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    rx_valid = 1'b0;
    check_status(tag, 1'b0, 1'b1, 1'b1, 1'b0);
    idle_cycles(3);
    clear_and_check(tag);
  endtask

  initial begin
    logic [7:0] cs;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    clear    = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("post_reset");

    // Two-word example image.
    fw = {32'h12345678, 32'hDEADBEEF};
    run_frame("two_words", 1'b0, 8'h00, 0);
    clear_and_check("two_words");

    // Garbage before sync is ignored.
    send_byte(8'h00);
    send_byte(8'hFF);
    fw = {32'h04030201};
    run_frame("leading_junk", 1'b0, 8'h00, 0);
    clear_and_check("leading_junk");

    // Wrong checksum: writes still happen, then error.
    fw = {32'h11223344, 32'hCAFEF00D};
    run_frame("bad_csum", 1'b1, 8'h00, 1);
    clear_and_check("bad_csum");

    // Illegal lengths.
    bad_len("len_zero", 16'd0);
    bad_len("len_2049", 16'd2049);
    bad_len("len_depth_p1", 16'(DEPTH + 1));

    // Largest legal length at the boundary is covered by back-to-back below;
    // here the idle timeout inside a partial word.
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    idle_cycles(TIMEOUT - 2);
    chk("timeout_before_error", {31'd0, error}, 32'd0);
    idle_cycles(3);
    check_status("timeout", 1'b0, 1'b1, 1'b1, 1'b0);
    chk("timeout_no_write", 32'(exp_addr.size()), 32'd0);
    clear_and_check("timeout");

    // In DONE, offered bytes are refused and nothing changes.
    fw = {$urandom()};
    run_frame("done_hold", 1'b0, 8'h00, 0);
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    repeat (5) @(negedge clk);
    check_status("done_hold_valid", 1'b1, 1'b0, 1'b0, 1'b0);
    clear_and_check("done_hold");

    // clear mid-frame is ignored.
    exp_addr.push_back(32'd0);
    exp_data.push_back(32'h44332211);
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    pulse_clear();
    chk("clear_in_data_error", {31'd0, error}, 32'd0);
    cs = 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44;
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(cs);
    idle_cycles(2);
    check_status("clear_in_data", 1'b1, 1'b0, 1'b0, 1'b0);
    clear_and_check("clear_in_data");

    // Reset after two bytes of the second word: partial word discarded.
    exp_addr.push_back(32'd0);
    exp_data.push_back(32'hDDCCBBAA);
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    send_byte(8'hEE);
    send_byte(8'hFF);
    rx_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_vals("mid_word_rst");
    idle_cycles(4);
    chk("mid_word_rst_no_write", {31'd0, mem_wen}, 32'd0);
    fw = {$urandom(), $urandom(), $urandom()};
    run_frame("after_rst", 1'b0, 8'h00, 0);
    clear_and_check("after_rst");

    // Randomised frames with gaps and occasional corrupted checksums.
    for (int it = 0; it < 8; it++) begin
      fw = {};
      for (int i = 0; i < int'($urandom_range(6, 1)); i++) fw.push_back($urandom());
      run_frame("random", ($urandom_range(3, 0) == 0), 8'($urandom()), 3);
      clear_and_check("random");
    end

    // Full-depth image, a byte on every cycle.
    fw = {};
    for (int i = 0; i < DEPTH; i++) fw.push_back($urandom());
    run_frame("full_depth", 1'b0, 8'h00, 0);
    clear_and_check("full_depth");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
